// File: rtl/t03_text_pkg.sv
// Shared sizes, character codes and scan state for the text scan-out block.
package t03_text_pkg;

  localparam int unsigned NUM_CHARS = 12;
  localparam int unsigned X_LEN     = 9;
  localparam int unsigned Y_LEN     = 8;
  localparam int unsigned CHAR_BITS = X_LEN * Y_LEN;
  localparam int unsigned CHAR_SIZE = 6;

  localparam int unsigned ROW_W = NUM_CHARS * X_LEN;
  localparam int unsigned TOTAL = ROW_W * Y_LEN;
  localparam int unsigned XW    = $clog2(ROW_W);
  localparam int unsigned YW    = $clog2(Y_LEN);
  localparam int unsigned CW    = $clog2(NUM_CHARS);
  localparam int unsigned KW    = $clog2(X_LEN);
  localparam int unsigned IW    = $clog2(TOTAL);

  // Character codes as understood by the glyph LUT
  localparam logic [CHAR_SIZE-1:0] CH_A = 6'd0,  CH_B = 6'd1,  CH_C = 6'd2,  CH_D = 6'd3,
                                   CH_E = 6'd4,  CH_F = 6'd5,  CH_G = 6'd6,  CH_H = 6'd7,
                                   CH_I = 6'd8,  CH_J = 6'd9,  CH_K = 6'd10, CH_L = 6'd11,
                                   CH_M = 6'd12, CH_N = 6'd13, CH_O = 6'd14, CH_P = 6'd15,
                                   CH_Q = 6'd16, CH_R = 6'd17, CH_S = 6'd18, CH_T = 6'd19,
                                   CH_U = 6'd20, CH_V = 6'd21, CH_W = 6'd22, CH_X = 6'd23,
                                   CH_Y = 6'd24, CH_Z = 6'd25;
  localparam logic [CHAR_SIZE-1:0] CH_0 = 6'd26, CH_1 = 6'd27, CH_2 = 6'd28, CH_3 = 6'd29,
                                   CH_4 = 6'd30, CH_5 = 6'd31, CH_6 = 6'd32, CH_7 = 6'd33,
                                   CH_8 = 6'd34, CH_9 = 6'd35, CH_SPACE = 6'd37;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scan_state_e;

endpackage

// File: rtl/t03_text_scanout_if.sv
// Pixel stream toward the display driver: valid/ready plus pixel payload and coordinates.
interface t03_text_scanout_if;
  import t03_text_pkg::*;

  logic          pixel_valid;
  logic          pixel_ready;
  logic          pixel_data;
  logic [XW-1:0] pixel_x;
  logic [YW-1:0] pixel_y;
  logic [CW-1:0] pixel_char;
  logic          row_done;

  modport master (
    output pixel_valid, pixel_data, pixel_x, pixel_y, pixel_char, row_done,
    input  pixel_ready
  );

  modport slave (
    input  pixel_valid, pixel_data, pixel_x, pixel_y, pixel_char, row_done,
    output pixel_ready
  );
endinterface

// File: rtl/t03_text_scan_ctr.sv
// Raster position counters: column-in-char / char / row nest, plus a flat strip column.
module t03_text_scan_ctr
  import t03_text_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic [CW-1:0] ch,
  output logic          last_c
);

  logic [KW-1:0] k;

  assign last_c = (k == KW'(X_LEN - 1)) && (ch == CW'(NUM_CHARS - 1)) && (y == YW'(Y_LEN - 1));

  // The final pixel does not advance, so coordinates stay parked on it until the next clear
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      k  <= '0;
      ch <= '0;
      y  <= '0;
      x  <= '0;
    end else if (en && !last_c) begin
      if (k == KW'(X_LEN - 1)) begin
        k <= '0;
        if (ch == CW'(NUM_CHARS - 1)) begin
          ch <= '0;
          y  <= y + YW'(1);
        end else begin
          ch <= ch + CW'(1);
        end
      end else begin
        k <= k + KW'(1);
      end
      x <= (x == XW'(ROW_W - 1)) ? '0 : x + XW'(1);
    end
  end

endmodule

// File: rtl/t03_text_scanout.sv
// Snapshots a glyph strip on start and streams it pixel by pixel in raster order.
module t03_text_scanout
  import t03_text_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [TOTAL-1:0] characters,
  output logic             busy,
  output logic             frame_done,
  t03_text_scanout_if.master bus
);

  scan_state_e      state_q, state_d;
  logic [TOTAL-1:0] shadow_q;
  logic             load;
  logic             xfer;
  logic             last_c;
  logic [XW-1:0]    x;
  logic [YW-1:0]    y;
  logic [CW-1:0]    ch;
  logic [IW-1:0]    idx_c;

  t03_text_scan_ctr u_ctr (
    .clk    (clk),
    .rst    (rst),
    .clr    (load),
    .en     (xfer),
    .x      (x),
    .y      (y),
    .ch     (ch),
    .last_c (last_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      shadow_q <= '0;
    end else begin
      state_q <= state_d;
      if (load) shadow_q <= characters;
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        load    = 1'b1;
        state_d = SCAN;
      end
      SCAN: if (xfer && last_c) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strip MSB is row 0, column 0
  assign idx_c = IW'(TOTAL - 1) - IW'(ROW_W) * IW'(y) - IW'(x);

  assign xfer            = bus.pixel_valid && bus.pixel_ready;
  assign bus.pixel_valid = (state_q == SCAN);
  assign bus.pixel_data  = shadow_q[idx_c];
  assign bus.pixel_x     = x;
  assign bus.pixel_y     = y;
  assign bus.pixel_char  = ch;
  assign bus.row_done    = (state_q == SCAN) && (x == XW'(ROW_W - 1));
  assign busy            = (state_q != IDLE);
  assign frame_done      = (state_q == DONE);

endmodule

// File: tb/tb_t03_text_scanout.sv
// Directed bench for t03_text_scanout: raster order, backpressure, restart immunity, reset, back-to-back.
module tb_t03_text_scanout;
  import t03_text_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [TOTAL-1:0] characters;
  logic             busy;
  logic             frame_done;

  t03_text_scanout_if bus ();

  t03_text_scanout dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .characters (characters),
    .busy       (busy),
    .frame_done (frame_done),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Hand-drawn 'A' glyph, bit 8 = column 0
  logic [8:0] glyph_a [8] = '{9'b001110000, 9'b010001000, 9'b100000100, 9'b100000100,
                              9'b111111100, 9'b100000100, 9'b100000100, 9'b000000000};

  logic [TOTAL-1:0] strip_a;
  logic [TOTAL-1:0] strip_one;

  int n_xfer, n_rows, n_bad, n_hold, n_stall, lit_cnt, lit_x, lit_y, lit_ch, lit_rd, char9;
  int fd_next;
  int row0 [ROW_W];

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Consumes a frame starting at (0,0); compares each transfer against the raster model of snap
  task automatic stream(input logic [TOTAL-1:0] snap, input bit do_stall, input bit do_pulse,
                        input bit do_rst, input bit keep_start);
    int  ex, ey, cyc;
    bit  last, rdy, expd;
    ex = 0; ey = 0; cyc = 0; last = 1'b0;
    n_xfer = 0; n_rows = 0; n_bad = 0; n_hold = 0; n_stall = 0;
    lit_cnt = 0; lit_x = -1; lit_y = -1; lit_ch = -1; lit_rd = -1; char9 = -1; fd_next = 0;
    while (!last && cyc < 3000) begin
      if (!bus.pixel_valid) begin
        n_bad++;
        break;
      end
      rdy = 1'b1;
      if (do_stall && ex == 40 && ey == 3 && n_stall < 5) begin
        rdy = 1'b0;
        if (int'(bus.pixel_x) != 40 || int'(bus.pixel_y) != 3 || int'(bus.pixel_char) != 4)
          n_hold++;
        n_stall++;
      end
      if (do_pulse && ex == 100 && ey == 2) begin
        start      = 1'b1;
        characters = '0;
      end else if (!keep_start) begin
        start = 1'b0;
      end
      if (do_rst && ey == 5 && ex == 0) begin
        rst = 1'b1;
        break;
      end
      bus.pixel_ready = rdy;
      if (rdy) begin
        expd = snap[TOTAL - 1 - ey * ROW_W - ex];
        if (int'(bus.pixel_x) != ex || int'(bus.pixel_y) != ey ||
            int'(bus.pixel_char) != ex / X_LEN || bus.pixel_data !== expd ||
            bus.row_done !== (ex == ROW_W - 1))
          n_bad++;
        if (ey == 0) row0[ex] = int'(bus.pixel_data);
        if (ey == 0 && ex == 9) char9 = int'(bus.pixel_char);
        if (bus.pixel_data) begin
          lit_cnt++;
          lit_x = int'(bus.pixel_x); lit_y = int'(bus.pixel_y);
          lit_ch = int'(bus.pixel_char); lit_rd = int'(bus.row_done);
        end
        if (bus.row_done) n_rows++;
        n_xfer++;
        if (ex == ROW_W - 1) begin
          ex = 0;
          if (ey == Y_LEN - 1) last = 1'b1;
          ey++;
        end else begin
          ex++;
        end
      end
      tick();
      cyc++;
    end
    if (last) fd_next = int'(frame_done && !bus.pixel_valid);
  endtask

  task automatic kick(input logic [TOTAL-1:0] strip);
    characters = strip;
    start      = 1'b1;
    tick();
  endtask

  initial begin
    for (int yy = 0; yy < Y_LEN; yy++)
      for (int c = 0; c < NUM_CHARS; c++)
        for (int k = 0; k < X_LEN; k++)
          strip_a[TOTAL - 1 - yy * ROW_W - c * X_LEN - k] = glyph_a[yy][8 - k];
    strip_one    = '0;
    strip_one[0] = 1'b1;

    rst = 1'b1; start = 1'b0; characters = '0; bus.pixel_ready = 1'b1;
    tick(); tick();
    chk("rst_valid", int'(bus.pixel_valid), 0);
    chk("rst_data", int'(bus.pixel_data), 0);
    chk("rst_x", int'(bus.pixel_x), 0);
    chk("rst_y", int'(bus.pixel_y), 0);
    chk("rst_char", int'(bus.pixel_char), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_row_done", int'(bus.row_done), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    rst = 1'b0;

    // T1: all-'A' strip, start on the first IDLE cycle
    kick(strip_a);
    chk("t1_valid_first", int'(bus.pixel_valid), 1);
    chk("t1_busy", int'(busy), 1);
    stream(strip_a, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t1_pix0", row0[0], 0); chk("t1_pix1", row0[1], 0); chk("t1_pix2", row0[2], 1);
    chk("t1_pix3", row0[3], 1); chk("t1_pix4", row0[4], 1); chk("t1_pix5", row0[5], 0);
    chk("t1_pix6", row0[6], 0); chk("t1_pix7", row0[7], 0); chk("t1_pix8", row0[8], 0);
    chk("t1_char9_pat", int'(row0[9] == 0 && row0[10] == 0 && row0[11] == 1 && row0[12] == 1 &&
                             row0[13] == 1 && row0[14] == 0 && row0[17] == 0), 1);
    chk("t1_char_at_x9", char9, 1);
    chk("t1_raster", n_bad, 0);
    chk("t1_xfers", n_xfer, 864);
    chk("t1_rows", n_rows, 8);
    chk("t1_frame_done", fd_next, 1);
    tick();
    chk("t1_fd_single", int'(frame_done), 0);
    chk("t1_idle_busy", int'(busy), 0);

    // T2: five-cycle stall at x=40, y=3
    kick(strip_a);
    stream(strip_a, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t2_stalls", n_stall, 5);
    chk("t2_hold", n_hold, 0);
    chk("t2_raster", n_bad, 0);
    chk("t2_xfers", n_xfer, 864);
    chk("t2_frame_done", fd_next, 1);
    tick();

    // T3: start and zeroed characters mid-frame must not disturb the snapshot
    kick(strip_a);
    stream(strip_a, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t3_raster", n_bad, 0);
    chk("t3_xfers", n_xfer, 864);
    chk("t3_frame_done", fd_next, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3_no_extra_frame", int'(frame_done || busy), 0);
    end

    // T4: reset at the start of row 5
    kick(strip_a);
    stream(strip_a, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t4_reached_row5", n_xfer, 5 * ROW_W);
    tick();
    rst = 1'b0;
    chk("t4_valid", int'(bus.pixel_valid), 0);
    chk("t4_busy", int'(busy), 0);
    chk("t4_x", int'(bus.pixel_x), 0);
    chk("t4_y", int'(bus.pixel_y), 0);
    chk("t4_no_fd", int'(frame_done), 0);
    kick(strip_a);
    chk("t4_restart_xy", int'(bus.pixel_valid && bus.pixel_x == 0 && bus.pixel_y == 0), 1);
    stream(strip_a, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t4_raster", n_bad, 0);
    chk("t4_frame_done", fd_next, 1);
    tick();

    // T5: only the last pixel of the strip lit
    kick(strip_one);
    stream(strip_one, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t5_lit_cnt", lit_cnt, 1);
    chk("t5_lit_x", lit_x, 107);
    chk("t5_lit_y", lit_y, 7);
    chk("t5_lit_char", lit_ch, 11);
    chk("t5_lit_row_done", lit_rd, 1);
    tick();

    // T6: start held high gives back-to-back frames with one IDLE gap
    kick(strip_a);
    stream(strip_a, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t6_raster", n_bad, 0);
    chk("t6_frame_done", fd_next, 1);
    tick();
    chk("t6_idle_gap", int'(busy || bus.pixel_valid || frame_done), 0);
    tick();
    chk("t6_second_frame", int'(bus.pixel_valid && bus.pixel_x == 0 && bus.pixel_y == 0), 1);
    stream(strip_a, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t6_second_raster", n_bad, 0);
    chk("t6_second_fd", fd_next, 1);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/t03_text_scanout.md
Name: t03_text_scanout

Overview:
- Consumer of the flattened glyph strip produced by the team's character LUT: 8 rows x 9 columns per character, rows of all characters concatenated, MSB = row 0, character 0, column 0.
- On `start`, snapshots the strip into a shadow register.
- Streams it one pixel per transfer, in row-major raster order, over a valid/ready interface toward the display driver.
- Reports pixel coordinates and row/frame completion.

Parameters:
- NUM_CHARS, 12, characters per strip.
- X_LEN, 9, pixel columns per character.
- Y_LEN, 8, pixel rows per character.
- Derived localparams:
  - ROW_W = NUM_CHARS*X_LEN (108)
  - TOTAL = ROW_W*Y_LEN (864)
  - XW = $clog2(ROW_W) (7)
  - YW = $clog2(Y_LEN) (3)
  - CW = $clog2(NUM_CHARS) (4)
  - KW = $clog2(X_LEN) (4)

Ports:
- clk  in  1  clock; one clock domain.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a frame; honoured only in IDLE.
- characters  in  TOTAL  glyph strip, LUT layout.
- pixel_ready  in  1  downstream accepts the pixel this cycle.
- pixel_valid  out  1  pixel_data and coordinates are valid.
- pixel_data  out  1  current pixel (1 = lit).
- pixel_x  out  XW  column within the strip, 0..ROW_W-1.
- pixel_y  out  YW  row, 0..Y_LEN-1.
- pixel_char  out  CW  character index, 0..NUM_CHARS-1.
- busy  out  1  high in SCAN and DONE.
- row_done  out  1  high while the last pixel of a row is presented (qualify with valid&ready).
- frame_done  out  1  one-cycle pulse after the final transfer.

Behaviour:
- Reset:
  - All outputs 0.
  - State IDLE.
  - All counters 0.
  - Shadow register 0.
  - Reset overrides everything, including mid-frame: the next cycle is IDLE, with no frame_done.
- States:
  - IDLE:
    - start=1 → latch characters into the shadow register, clear counters, go to SCAN.
    - start=0 → stay in IDLE.
  - SCAN:
    - pixel_valid=1 throughout.
    - A transfer occurs when pixel_valid & pixel_ready.
    - On a transfer that is not the last pixel, advance the counters.
    - On the transfer of pixel (x=ROW_W-1, y=Y_LEN-1) → go to DONE.
  - DONE:
    - frame_done=1 and pixel_valid=0 for one cycle, then IDLE.
- Latency:
  - start sampled at edge N → pixel_valid=1 with (x=0, y=0) from edge N+1.
  - With pixel_ready held high: one pixel per cycle, TOTAL cycles in SCAN.
  - frame_done is asserted on the cycle after the last transfer.
- Pixel mapping:
  - pixel_data = shadow[TOTAL-1 - y*ROW_W - x].
  - x = pixel_char*X_LEN + k, where k (0..X_LEN-1) is the column within the character.
- Counters:
  - Nested: k wraps at X_LEN-1 and increments pixel_char.
  - pixel_char wraps at NUM_CHARS-1 and increments y.
  - pixel_x is a separate counter that wraps at ROW_W-1 (no multiplier).
- Handshake:
  - While pixel_valid & !pixel_ready, pixel_data, pixel_x, pixel_y, pixel_char and row_done hold stable.
  - pixel_valid never drops in SCAN until the final transfer.
- row_done is combinational from the counters: x==ROW_W-1 in SCAN.
- busy=1 in SCAN and DONE.
- start while busy is ignored: no restart, no re-latch.
- The characters input may change at any time after the latch; the output depends only on the snapshot.
- start asserted in the same cycle as DONE is ignored. start on the first IDLE cycle is accepted.

Decomposition:
- Package t03_text_pkg holds:
  - NUM_CHARS, X_LEN, Y_LEN, CHAR_BITS (=X_LEN*Y_LEN), CHAR_SIZE (6).
  - Character-code constants: CH_A=0 … CH_Z=25, CH_0=26 … CH_9=35, CH_SPACE=37.
  - The scan state enum {IDLE, SCAN, DONE}.
- One sub-module: t03_text_scan_ctr.
  - Function: nested k/char/y counters plus the pixel_x counter, with enable (=transfer) and clear inputs.
  - Outputs: the counter values and a last flag.
- The top-level module holds the FSM, the shadow register and the bit select.

Test Plan:
1. All-'A' strip (12×code 0 through t03_text_lut), start with pixel_ready=1:
   - First 9 pixel_data values = 0,0,1,1,1,0,0,0,0.
   - Pixel x=9 begins the same pattern with pixel_char=1.
   - 864 transfers, exactly 8 row_done transfers, frame_done one cycle after the last transfer.
2. Backpressure: pixel_ready low for 5 cycles at x=40, y=3:
   - Outputs hold (x=40, y=3, pixel_char=4) for all 5 cycles.
   - No pixel is skipped or duplicated; the total is still 864.
3. start pulsed at x=100, y=2, and characters changed to all-zero mid-frame:
   - No restart.
   - The output still matches the original snapshot.
   - Exactly one frame_done.
4. rst asserted at y=5:
   - The next cycle has pixel_valid=0, busy=0, x=y=0, and no frame_done.
   - A new start then streams from (0,0).
5. Single lit pixel at characters[TOTAL-1-7*108-107]:
   - pixel_data=1 only at x=107, y=7, pixel_char=11, coinciding with row_done.
6. start held high continuously:
   - Frames repeat back to back with exactly one IDLE cycle between DONE and the next SCAN.
